// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the multiplier family (sequential shift-add and
// the flat combinational array multiplier).
//   state_t       : control states of the sequential multiplier
//   DEFAULT_WIDTH : default operand width shared by both multipliers
//   cnt_width()   : bits needed for an iteration counter that reaches WIDTH
package mul_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Counter must be able to hold the value WIDTH itself, hence w+1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mul_abs.sv
// mul_abs
// Combinational conditional magnitude of a WIDTH-bit operand.
//   value     : in  WIDTH  raw operand
//   is_signed : in  1      1 = treat value as two's complement
//   mag       : out WIDTH  |value| when signed, value unchanged otherwise
// The magnitude of the most negative value wraps to itself, which is the
// correct unsigned magnitude 2^(WIDTH-1), so no extra bit is needed.
module mul_abs #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] value,
   input  logic             is_signed,
   output logic [WIDTH-1:0] mag
);

   // Negate only negative two's-complement inputs; unsigned values pass through.
   always_comb begin
      mag = value;
      if (is_signed && value[WIDTH-1])
         mag = ~value + WIDTH'(1);
   end

endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul
// Iterative shift-add multiplier, one 2*WIDTH-bit product per request,
// unsigned or signed per request, valid/ready on both sides.
//   clk       : in  1        rising-edge clock
//   rst_n     : in  1        synchronous active-low reset
//   in_valid  : in  1        request present
//   in_ready  : out 1        request can be taken (IDLE only)
//   a         : in  WIDTH    multiplier operand
//   b         : in  WIDTH    multiplicand operand
//   is_signed : in  1        two's-complement operands when 1
//   out_valid : out 1        p holds a product
//   out_ready : in  1        consumer takes p
//   p         : out 2*WIDTH  registered product
// The multiply runs on operand magnitudes and the sign is applied once at
// the end, so the iteration loop is a plain unsigned shift-add.
module seq_shift_add_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);

   localparam int CW = cnt_width(WIDTH);

   state_t               state;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc;
   logic                 neg;
   logic [CW-1:0]        cnt;
   logic [WIDTH:0]       partial;

   mul_abs #(.WIDTH(WIDTH)) u_abs_a (
      .value     (a),
      .is_signed (is_signed),
      .mag       (a_mag)
   );

   mul_abs #(.WIDTH(WIDTH)) u_abs_b (
      .value     (b),
      .is_signed (is_signed),
      .mag       (b_mag)
   );

   // Upper accumulator half plus the multiplicand when the current
   // multiplier bit is set; the extra MSB keeps the carry for the shift.
   always_comb begin
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (mplier[0])
         partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
   end

   // Control and datapath in one block. in_ready and out_valid are
   // registered alongside the state so no input reaches an output
   // combinationally. p keeps its last product through IDLE and is only
   // cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         mplier    <= '0;
         mcand     <= '0;
         neg       <= 1'b0;
         p         <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mplier   <= a_mag;
                  mcand    <= b_mag;
                  neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc    <= {partial, acc[WIDTH-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               p         <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul
// Drives a WIDTH=16 and a WIDTH=8 instance of seq_shift_add_mul with
// directed corner cases and random requests, comparing every product
// against a plain-arithmetic reference.
module tb_seq_shift_add_mul;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid16;
   logic        in_valid8;
   logic [15:0] a;
   logic [15:0] b;
   logic        is_signed;
   logic        out_ready;

   logic        in_ready16;
   logic        out_valid16;
   logic [31:0] p16;
   logic        in_ready8;
   logic        out_valid8;
   logic [15:0] p8;

   int          sel;
   logic        cur_in_ready;
   logic        cur_out_valid;
   logic [31:0] cur_p;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   seq_shift_add_mul #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .p         (p16)
   );

   seq_shift_add_mul #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a[7:0]),
      .b         (b[7:0]),
      .is_signed (is_signed),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .p         (p8)
   );

   // Route the selected instance's outputs to one set of observation signals.
   always_comb begin
      cur_in_ready  = in_ready16;
      cur_out_valid = out_valid16;
      cur_p         = p16;
      if (sel == 8) begin
         cur_in_ready  = in_ready8;
         cur_out_valid = out_valid8;
         cur_p         = {16'h0000, p8};
      end
   end

   // Single comparison point: counts every check, reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference product: interpret the low w bits as integers, multiply,
   // keep the low 2*w bits.
   function automatic logic [31:0] refProduct(input logic [15:0] x, input logic [15:0] y,
                                              input logic s, input int w);
      longint xi;
      longint yi;
      longint prod;
      longint lim;
      lim = longint'(1) << w;
      xi  = longint'(x) % lim;
      yi  = longint'(y) % lim;
      if (s && xi >= lim / 2) xi = xi - lim;
      if (s && yi >= lim / 2) yi = yi - lim;
      prod = (xi * yi) % (lim * lim);
      if (prod < 0) prod = prod + lim * lim;
      return 32'(prod);
   endfunction

   task automatic setValid(input int w, input logic v);
      if (w == 8) in_valid8 = v;
      else        in_valid16 = v;
   endtask

   // One full transaction: request, latency, optional backpressure, release.
   task automatic applyStimulus(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic s, input int holdCycles, input string tag);
      logic [31:0] expP;
      int          cycles;
      expP = refProduct(av, bv, s, w);
      sel  = w;
      @(negedge clk);
      a         = av;
      b         = bv;
      is_signed = s;
      out_ready = 1'b0;
      setValid(w, 1'b1);
      cycles = 0;
      while (!cur_in_ready && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      if (!cur_in_ready) begin
         checkOutput({tag, ":ready_timeout"}, 64'(cur_in_ready), 64'(1));
         setValid(w, 1'b0);
         return;
      end
      @(posedge clk);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            setValid(w, 1'b0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            is_signed = 1'($urandom);
         end
      end while (!cur_out_valid && cycles < 100);
      checkOutput({tag, ":latency"}, 64'(cycles), 64'(w + 2));
      if (!cur_out_valid) return;
      checkOutput({tag, ":p"}, 64'(cur_p), 64'(expP));
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput({tag, ":hold_valid"}, 64'(cur_out_valid), 64'(1));
         checkOutput({tag, ":hold_p"}, 64'(cur_p), 64'(expP));
         checkOutput({tag, ":hold_in_ready"}, 64'(cur_in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, ":release_in_ready"}, 64'(cur_in_ready), 64'(1));
      checkOutput({tag, ":release_valid"}, 64'(cur_out_valid), 64'(0));
   endtask

   // Start a request on the 16-bit instance and pulse reset during its
   // fifth BUSY cycle.
   task automatic applyMidReset();
      int cycles;
      sel = 16;
      @(negedge clk);
      a          = 16'h1234;
      b          = 16'h5678;
      is_signed  = 1'b0;
      out_ready  = 1'b0;
      in_valid16 = 1'b1;
      cycles = 0;
      while (!in_ready16 && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("mid_reset:ready", 64'(in_ready16), 64'(1));
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid16 = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mid_reset:out_valid", 64'(out_valid16), 64'(0));
      checkOutput("mid_reset:p", 64'(p16), 64'(0));
      checkOutput("mid_reset:in_ready", 64'(in_ready16), 64'(1));
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid16 = 1'b0;
      in_valid8  = 1'b0;
      a          = '0;
      b          = '0;
      is_signed  = 1'b0;
      out_ready  = 1'b0;
      sel        = 16;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] reset state");
      checkOutput("reset:in_ready16", 64'(in_ready16), 64'(1));
      checkOutput("reset:out_valid16", 64'(out_valid16), 64'(0));
      checkOutput("reset:p16", 64'(p16), 64'(0));
      checkOutput("reset:in_ready8", 64'(in_ready8), 64'(1));
      checkOutput("reset:out_valid8", 64'(out_valid8), 64'(0));
      checkOutput("reset:p8", 64'(p8), 64'(0));

      $display("[TB] directed 16-bit cases");
      applyStimulus(16, 16'd221,   16'd332,   1'b0, 0, "u_221x332");
      applyStimulus(16, 16'd2598,  16'd6419,  1'b0, 0, "u_2598x6419");
      applyStimulus(16, 16'hFFFF,  16'h0FFF,  1'b0, 0, "u_ffffx0fff");
      applyStimulus(16, 16'hFFFF,  16'h0FFF,  1'b1, 0, "s_ffffx0fff");
      applyStimulus(16, 16'h8000,  16'h8000,  1'b1, 0, "s_minxmin");
      applyStimulus(16, 16'h8000,  16'h0001,  1'b1, 0, "s_minx1");
      applyStimulus(16, 16'h0000,  16'h8000,  1'b1, 0, "s_0xmin");
      applyStimulus(16, 16'd221,   16'd332,   1'b0, 5, "backpressure");

      $display("[TB] reset during BUSY");
      applyMidReset();
      applyStimulus(16, 16'd10,    16'd1024,  1'b0, 0, "after_reset");

      $display("[TB] directed 8-bit cases");
      applyStimulus(8, 16'h00FF, 16'h00FF, 1'b0, 0, "w8_u_255x255");
      applyStimulus(8, 16'h0080, 16'h007F, 1'b1, 0, "w8_s_80x7f");

      $display("[TB] random 16-bit requests");
      for (int i = 0; i < 30; i++)
         applyStimulus(16, 16'($urandom), 16'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)), "rand16");

      $display("[TB] random 8-bit requests");
      for (int i = 0; i < 20; i++)
         applyStimulus(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                       1'($urandom), int'($urandom_range(0, 3)), "rand8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
